// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between a command source and alu_op_sequencer.
// master drives commands and consumes responses; slave is the sequencer side.
interface alu_op_sequencer_if #(
   parameter int AWIDTH    = 3,
   parameter int DWIDTH    = 8,
   parameter int ALU_SEL_W = 3
) ();
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ALU_SEL_W-1:0] cmd_op;
   logic [AWIDTH-1:0]    cmd_rs1;
   logic [AWIDTH-1:0]    cmd_rs2;
   logic [AWIDTH-1:0]    cmd_rd;
   logic                 cmd_use_imm;
   logic [DWIDTH-1:0]    cmd_imm;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DWIDTH-1:0]    rsp_res;
   logic                 rsp_zero;
   logic                 rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_use_imm, cmd_imm, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_use_imm, cmd_imm, rsp_ready,
      output cmd_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Execute-stage sequencer: accept command, drive ALU/regbank for one cycle, write back, respond.
// Legal op: EXEC at T+1, wen at T+2, rsp_valid from T+3; cmd_ready low until the response is taken.
module alu_op_sequencer #(
   parameter int AWIDTH    = 3,
   parameter int DWIDTH    = 8,
   parameter int ALU_SEL_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_op_sequencer_if.slave    bus,
   output logic [AWIDTH-1:0]    raddr1,
   output logic [AWIDTH-1:0]    raddr2,
   output logic                 mux_sel,
   output logic [DWIDTH-1:0]    imm_out,
   output logic [ALU_SEL_W-1:0] alu_sel,
   input  logic [DWIDTH-1:0]    alu_res,
   input  logic                 alu_res_is_0,
   output logic [AWIDTH-1:0]    waddr,
   output logic [DWIDTH-1:0]    wdata,
   output logic                 wen
);

   typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

   state_t               state_q, state_d;
   logic [AWIDTH-1:0]    raddr1_q, raddr1_d;
   logic [AWIDTH-1:0]    raddr2_q, raddr2_d;
   logic [ALU_SEL_W-1:0] alu_sel_q, alu_sel_d;
   logic                 mux_sel_q, mux_sel_d;
   logic [DWIDTH-1:0]    imm_out_q, imm_out_d;
   logic [AWIDTH-1:0]    rd_q, rd_d;
   logic [DWIDTH-1:0]    res_q, res_d;
   logic                 zero_q, zero_d;
   logic                 err_q, err_d;
   logic                 op_legal;

   always_comb begin
      op_legal = 1'b0;
      case (bus.cmd_op)
         ALU_SEL_W'(0), ALU_SEL_W'(1), ALU_SEL_W'(2),
         ALU_SEL_W'(6), ALU_SEL_W'(7): op_legal = 1'b1;
         default:                     op_legal = 1'b0;
      endcase
   end

   // ALU-facing fields only load on a legal accept so they hold steady outside EXEC.
   always_comb begin
      state_d   = state_q;
      raddr1_d  = raddr1_q;
      raddr2_d  = raddr2_q;
      alu_sel_d = alu_sel_q;
      mux_sel_d = mux_sel_q;
      imm_out_d = imm_out_q;
      rd_d      = rd_q;
      res_d     = res_q;
      zero_d    = zero_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               rd_d = bus.cmd_rd;
               if (op_legal) begin
                  raddr1_d  = bus.cmd_rs1;
                  raddr2_d  = bus.cmd_rs2;
                  alu_sel_d = bus.cmd_op;
                  mux_sel_d = bus.cmd_use_imm;
                  imm_out_d = bus.cmd_imm;
                  state_d   = EXEC;
               end else begin
                  res_d   = '0;
                  zero_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         EXEC: begin
            res_d   = alu_res;
            zero_d  = alu_res_is_0;
            state_d = WB;
         end
         WB: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         raddr1_q  <= '0;
         raddr2_q  <= '0;
         alu_sel_q <= '0;
         mux_sel_q <= 1'b0;
         imm_out_q <= '0;
         rd_q      <= '0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         raddr1_q  <= raddr1_d;
         raddr2_q  <= raddr2_d;
         alu_sel_q <= alu_sel_d;
         mux_sel_q <= mux_sel_d;
         imm_out_q <= imm_out_d;
         rd_q      <= rd_d;
         res_q     <= res_d;
         zero_q    <= zero_d;
         err_q     <= err_d;
      end
   end

   // Write enable is gated by rst so a reset landing in WB never commits a partial write.
   assign wen           = (state_q == WB) && (rd_q != '0) && !rst;
   assign waddr         = rd_q;
   assign wdata         = res_q;
   assign raddr1        = raddr1_q;
   assign raddr2        = raddr2_q;
   assign alu_sel       = alu_sel_q;
   assign mux_sel       = mux_sel_q;
   assign imm_out       = imm_out_q;
   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_res   = res_q;
   assign bus.rsp_zero  = zero_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register bank and ALU environment, scoreboard against an arithmetic model.
module tb_alu_op_sequencer;
   logic       clk;
   logic       rst;
   logic [2:0] raddr1, raddr2, waddr, alu_sel;
   logic       mux_sel, wen, alu_zero;
   logic [7:0] imm_out, wdata, alu_res, rd1, rd2, src2;
   logic [7:0] rf [8];

   alu_op_sequencer_if #(.AWIDTH(3), .DWIDTH(8), .ALU_SEL_W(3)) bus ();

   alu_op_sequencer #(.AWIDTH(3), .DWIDTH(8), .ALU_SEL_W(3)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .raddr1(raddr1), .raddr2(raddr2), .mux_sel(mux_sel), .imm_out(imm_out),
      .alu_sel(alu_sel), .alu_res(alu_res), .alu_res_is_0(alu_zero),
      .waddr(waddr), .wdata(wdata), .wen(wen)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Environment: register bank with x0 hard-wired to zero, and the ALU.
   initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
   always @(posedge clk) if (wen && waddr != 3'd0) rf[waddr] <= wdata;
   assign rd1 = (raddr1 == 3'd0) ? 8'h00 : rf[raddr1];
   assign rd2 = (raddr2 == 3'd0) ? 8'h00 : rf[raddr2];
   always_comb begin
      src2 = mux_sel ? imm_out : rd2;
      case (alu_sel)
         3'd0:    alu_res = rd1 & src2;
         3'd1:    alu_res = rd1 | src2;
         3'd2:    alu_res = rd1 + src2;
         3'd6:    alu_res = rd1 - src2;
         3'd7:    alu_res = (rd1 < src2) ? 8'd1 : 8'd0;
         default: alu_res = 8'h00;
      endcase
   end
   assign alu_zero = (alu_res == 8'h00);

   typedef struct { logic [7:0] res; logic zero; logic err; } exp_t;
   exp_t sbq[$];
   logic [7:0] mreg [8];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = -100;
   int ready_mode = 1;
   bit exec_pend = 0, wr_pend = 0, e_err = 0;
   logic [2:0] e_rs1, e_rs2, e_rd, e_op;
   logic       e_ui;
   logic [7:0] e_imm, e_res;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (op == 3'd0) return a & b;
      if (op == 3'd1) return a | b;
      if (op == 3'd2) return 8'((int'(a) + int'(b)) % 256);
      if (op == 3'd6) return 8'((int'(a) - int'(b) + 256) % 256);
      return (int'(a) < int'(b)) ? 8'd1 : 8'd0;
   endfunction

   initial begin
      bus.rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
            2:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = 1'b1;
         endcase
      end
   end

   // Monitor: EXEC drive, writeback, latency, stall stability and the response scoreboard.
   bit         prev_valid = 0, prev_ready = 0;
   logic [7:0] prev_res;
   logic       prev_zero, prev_err;
   always @(negedge clk) begin
      if (!rst) begin
         if (exec_pend && cyc - acc_cyc == 1) begin
            chk("exec_raddr1", raddr1, e_rs1);
            chk("exec_raddr2", raddr2, e_rs2);
            chk("exec_alu_sel", alu_sel, e_op);
            chk("exec_mux_sel", mux_sel, e_ui);
            chk("exec_imm_out", imm_out, e_imm);
            exec_pend = 0;
         end
         if (wen) begin
            chk("wen_expected", wr_pend, 1);
            chk("wen_timing", cyc - acc_cyc, 2);
            chk("wb_waddr", waddr, e_rd);
            chk("wb_wdata", wdata, e_res);
            wr_pend = 0;
         end
         if (bus.rsp_valid && !prev_valid)
            chk("rsp_latency", cyc - acc_cyc, e_err ? 1 : 3);
         if (bus.rsp_valid && prev_valid && !prev_ready) begin
            chk("stall_res", bus.rsp_res, prev_res);
            chk("stall_zero", bus.rsp_zero, prev_zero);
            chk("stall_err", bus.rsp_err, prev_err);
            chk("stall_cmd_ready", bus.cmd_ready, 0);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("rsp_res", bus.rsp_res, e.res);
               chk("rsp_zero", bus.rsp_zero, e.zero);
               chk("rsp_err", bus.rsp_err, e.err);
               chk("wb_before_rsp", wr_pend, 0);
            end
         end
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
      prev_res   = bus.rsp_res;
      prev_zero  = bus.rsp_zero;
      prev_err   = bus.rsp_err;
   end

   task automatic send(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic ui, input logic [7:0] imm);
      int n;
      logic [7:0] a, b, r;
      bit legal;
      exp_t e;
      @(posedge clk);
      #1;
      bus.cmd_op = op; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_rd = rd;
      bus.cmd_use_imm = ui; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cmd_ready && n < 300);
      if (!bus.cmd_ready) begin
         chk("cmd_accept_timeout", 0, 1);
         bus.cmd_valid = 1'b0;
         return;
      end
      legal = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd6 || op == 3'd7);
      a = (rs1 == 3'd0) ? 8'h00 : mreg[rs1];
      b = ui ? imm : ((rs2 == 3'd0) ? 8'h00 : mreg[rs2]);
      r = legal ? model_alu(op, a, b) : 8'h00;
      e.res = r; e.zero = legal && (r == 8'h00); e.err = !legal;
      sbq.push_back(e);
      if (legal && rd != 3'd0) mreg[rd] = r;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      acc_cyc = cyc - 1;
      e_op = op; e_rs1 = rs1; e_rs2 = rs2; e_rd = rd; e_ui = ui; e_imm = imm; e_res = r;
      e_err = !legal;
      exec_pend = legal;
      wr_pend = legal && (rd != 3'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || bus.rsp_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", sbq.size(), 0);
   endtask

   initial begin
      logic [7:0] old6;
      int n;
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_rs1 = 3'd0; bus.cmd_rs2 = 3'd0;
      bus.cmd_rd = 3'd1; bus.cmd_use_imm = 1'b1; bus.cmd_imm = 8'h3C;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_wen", wen, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_res", bus.rsp_res, 0);
      chk("rst_rsp_zero", bus.rsp_zero, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_raddr1", raddr1, 0);
      chk("rst_raddr2", raddr2, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_mux_sel", mux_sel, 0);
      chk("rst_imm_out", imm_out, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      repeat (3) @(negedge clk);
      chk("rst_no_accept_rsp", bus.rsp_valid, 0);
      chk("rst_no_accept_x1", rf[1], 8'h00);

      send(3'd2, 3'd0, 3'd0, 3'd1, 1'b1, 8'h05);
      send(3'd1, 3'd0, 3'd0, 3'd2, 1'b1, 8'hFB);
      send(3'd2, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00);
      send(3'd2, 3'd0, 3'd0, 3'd1, 1'b1, 8'h10);
      send(3'd6, 3'd1, 3'd0, 3'd4, 1'b1, 8'h11);
      send(3'd3, 3'd1, 3'd2, 3'd5, 1'b0, 8'h00);
      drain();
      chk("x3_add_wrap", rf[3], 8'h00);
      chk("x4_sub_imm", rf[4], 8'hFF);
      chk("x5_untouched_by_illegal", rf[5], 8'h00);

      ready_mode = 2;
      send(3'd1, 3'd1, 3'd0, 3'd5, 1'b1, 8'h0F);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_seen", bus.rsp_valid, 1);
      repeat (5) @(posedge clk);
      ready_mode = 1;
      send(3'd2, 3'd5, 3'd1, 3'd6, 1'b0, 8'h00);
      send(3'd2, 3'd1, 3'd1, 3'd0, 1'b0, 8'h00);
      drain();
      chk("x6_reads_new_x5", rf[6], 8'h2F);

      old6 = rf[6];
      @(posedge clk);
      #1;
      bus.cmd_op = 3'd2; bus.cmd_rs1 = 3'd0; bus.cmd_rs2 = 3'd0; bus.cmd_rd = 3'd6;
      bus.cmd_use_imm = 1'b1; bus.cmd_imm = 8'h77; bus.cmd_valid = 1'b1;
      @(negedge clk);
      chk("wbrst_ready_before", bus.cmd_ready, 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("wbrst_wen_low", wen, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("wbrst_wen_after", wen, 0);
      chk("wbrst_idle", bus.cmd_ready, 1);
      chk("wbrst_rsp_valid", bus.rsp_valid, 0);
      chk("wbrst_x6_kept", rf[6], old6);

      ready_mode = 0;
      repeat (150) begin
         send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      drain();
      ready_mode = 1;
      for (int i = 1; i < 8; i++) chk($sformatf("final_x%0d", i), rf[i], mreg[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
